// File: rtl/fe_pkg.sv
// Shared field-arithmetic types and constants for the mod-p multiplier arbiter.
package fe_pkg;
  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RESP} state_t;

  localparam int FE_W = 255;
  typedef logic [FE_W-1:0] fe_t;

  // p = 2^255 - 19
  localparam fe_t P = {{247{1'b1}}, 8'hED};

  localparam int NREQ_DEF    = 4;
  localparam int TIMEOUT_DEF = 600;
endpackage

// File: rtl/mulp_arbiter_rr_pick.sv
// Round-robin picker: first set request after ptr, wrapping modulo NREQ.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx,
  output logic            any
);
  logic [IW-1:0] j;

  // Walk from the farthest offset down so the nearest hit after ptr wins.
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = '0;
    for (int k = NREQ; k >= 1; k--) begin
      j = IW'((int'(ptr) + k) % NREQ);
      if (req[j]) begin
        gnt    = '0;
        gnt[j] = 1'b1;
        idx    = j;
        any    = 1'b1;
      end
    end
  end
endmodule

// File: rtl/mulp_arbiter.sv
// Round-robin arbiter sharing one mod-p multiplier among NREQ requesters.
// Define MULP_ARB_TIMEOUT_EN to add a WAIT watchdog that answers with rsp_err.
module mulp_arbiter
  import fe_pkg::*;
#(
  parameter int N           = 255,
  parameter int NREQ        = NREQ_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*N-1:0] req_x,
  input  logic [NREQ*N-1:0] req_y,
  output logic [NREQ-1:0]   req_ready,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [N-1:0]      rsp_prod,
  output logic              rsp_err,
  output logic              busy,
  output logic              mul_en,
  output logic [N-1:0]      mul_x,
  output logic [N-1:0]      mul_y,
  input  logic [N-1:0]      mul_prod,
  input  logic              mul_dr
);
  localparam int IW = $clog2(NREQ);

  state_t          state, state_nx;
  logic [IW-1:0]   ptr, g_q, g_idx;
  logic [NREQ-1:0] g_hot;
  logic            g_any;
  logic            err_q;
  logic            tmo;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req (req_valid),
    .ptr (ptr),
    .gnt (g_hot),
    .idx (g_idx),
    .any (g_any)
  );

`ifdef MULP_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] cnt;

  // cnt equals the number of WAIT cycles already spent; zero on entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                cnt <= '0;
    else if (state != WAIT) cnt <= '0;
    else                    cnt <= cnt + CW'(1);
  end
  assign tmo = (state == WAIT) && (cnt == CW'(TIMEOUT_CYC - 1));
`else
  assign tmo = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (g_any) state_nx = LAUNCH;
      LAUNCH:  state_nx = WAIT;
      WAIT:    if (mul_dr || tmo) state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr      <= IW'(NREQ - 1);
      g_q      <= '0;
      mul_x    <= '0;
      mul_y    <= '0;
      rsp_prod <= '0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (g_any) begin
          g_q   <= g_idx;
          mul_x <= req_x[g_idx*N +: N];
          mul_y <= req_y[g_idx*N +: N];
        end
        WAIT: if (mul_dr) begin
          rsp_prod <= mul_prod;
          err_q    <= 1'b0;
        end else if (tmo) begin
          rsp_prod <= '0;
          err_q    <= 1'b1;
        end
        RESP:    ptr <= g_q;
        default: ;
      endcase
    end
  end

  // Gate the accept with rst so nothing leaks out while reset is held.
  assign req_ready = (state == IDLE && !rst) ? g_hot : '0;
  assign mul_en    = (state == LAUNCH);
  assign busy      = (state != IDLE);
  assign rsp_valid = (state == RESP) ? (NREQ'(1) << g_q) : '0;
  assign rsp_err   = (state == RESP) && err_q;
endmodule

// File: tb/tb_mulp_arbiter.sv
// Directed bench for mulp_arbiter with a fixed-latency modular multiplier stub.
module tb_mulp_arbiter;
  import fe_pkg::*;

  localparam int N   = 255;
  localparam int NR  = NREQ_DEF;
  localparam int TO  = 20;
  localparam int LAT = 5;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NR-1:0]   req_valid = '0;
  logic [NR*N-1:0] req_x = '0, req_y = '0;
  logic [NR-1:0]   req_ready, rsp_valid;
  logic [N-1:0]    rsp_prod, mul_x, mul_y, mul_prod;
  logic            rsp_err, busy, mul_en, mul_dr;

  logic            stub_hang = 1'b0;
  logic            auto_drop = 1'b1;
  logic [3:0]      scnt;

  int checks = 0, failures = 0, cyc = 0, bad = 0;
  int  acc_i[$], acc_c[$], en_c[$], rsp_i[$], rsp_c[$];
  fe_t en_x[$], rsp_p[$];
  logic rsp_e[$];

  mulp_arbiter #(.N(N), .NREQ(NR), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_x(req_x), .req_y(req_y), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_prod(rsp_prod), .rsp_err(rsp_err), .busy(busy),
    .mul_en(mul_en), .mul_x(mul_x), .mul_y(mul_y), .mul_prod(mul_prod), .mul_dr(mul_dr)
  );

  always #5 clk = ~clk;

  function automatic fe_t mulmod(fe_t a, fe_t b);
    logic [2*N-1:0] t;
    t = {{N{1'b0}}, a} * {{N{1'b0}}, b};
    return fe_t'(t % {{N{1'b0}}, P});
  endfunction

  // Multiplier stub: done rises LAT+1 cycles after the start pulse, stays high until the next start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scnt     <= '0;
      mul_dr   <= 1'b0;
      mul_prod <= '0;
    end else if (mul_en) begin
      scnt     <= 4'(LAT);
      mul_dr   <= 1'b0;
      mul_prod <= mulmod(mul_x, mul_y);
    end else if (scnt != 0) begin
      scnt <= scnt - 4'd1;
      if (scnt == 4'd1 && !stub_hang) mul_dr <= 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic int oh2i(logic [NR-1:0] v);
    for (int i = 0; i < NR; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic clear_logs();
    acc_i.delete(); acc_c.delete(); en_c.delete(); en_x.delete();
    rsp_i.delete(); rsp_c.delete(); rsp_p.delete(); rsp_e.delete();
    bad = 0;
  endtask

  // One clock: sample mid-cycle, log events, then drop accepted requests just after the edge.
  task automatic step();
    logic [NR-1:0] rdy;
    @(negedge clk);
    cyc++;
    rdy = req_ready;
    if (req_ready != 0) begin
      if (!$onehot(req_ready)) bad++;
      acc_i.push_back(oh2i(req_ready)); acc_c.push_back(cyc);
    end
    if (mul_en) begin en_c.push_back(cyc); en_x.push_back(mul_x); end
    if (rsp_valid != 0) begin
      if (!$onehot(rsp_valid)) bad++;
      rsp_i.push_back(oh2i(rsp_valid)); rsp_c.push_back(cyc);
      rsp_p.push_back(rsp_prod); rsp_e.push_back(rsp_err);
    end
    @(posedge clk); #1;
    if (auto_drop) req_valid = req_valid & ~rdy;
  endtask

  task automatic run_until_rsp(input int n, input int maxc);
    for (int k = 0; k < maxc && rsp_i.size() < n; k++) step();
    chk("rsp_count", rsp_i.size(), n);
  endtask

  task automatic run_until_acc(input int n, input int maxc);
    for (int k = 0; k < maxc && acc_i.size() < n; k++) step();
    chk("acc_count", acc_i.size(), n);
  endtask

  task automatic set_req(input int i, input fe_t x, input fe_t y);
    req_x[i*N +: N] = x;
    req_y[i*N +: N] = y;
    req_valid[i]    = 1'b1;
  endtask

  task automatic do_reset();
    req_valid = '0;
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    clear_logs();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    fe_t big;
    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_mul_en", mul_en, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_prod", rsp_prod, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_mul_x", mul_x, 0);
    chk("rst_mul_y", mul_y, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Single request from requester 0
    clear_logs();
    set_req(0, 3, 5);
    run_until_rsp(1, 40);
    chk("t1_acc_idx", acc_i[0], 0);
    chk("t1_en_after_acc", en_c[0] - acc_c[0], 1);
    chk("t1_en_count", en_c.size(), 1);
    chk("t1_mul_x", en_x[0], 3);
    chk("t1_rsp_idx", rsp_i[0], 0);
    chk("t1_prod", rsp_p[0], 15);
    chk("t1_err", rsp_e[0], 0);
    chk("t1_latency", rsp_c[0] - acc_c[0], LAT + 3);

    // Modular wrap cases
    clear_logs();
    big = fe_t'(1) << 254;
    set_req(1, big, 2);
    run_until_rsp(1, 40);
    chk("t2a_rsp_idx", rsp_i[0], 1);
    chk("t2a_prod", rsp_p[0], 19);
    clear_logs();
    set_req(3, P - 1, P - 1);
    run_until_rsp(1, 40);
    chk("t2b_rsp_idx", rsp_i[0], 3);
    chk("t2b_prod", rsp_p[0], 1);

    // Simultaneous requesters 0 and 2 after reset
    do_reset();
    set_req(0, 2, 3);
    set_req(2, 5, 7);
    run_until_rsp(2, 60);
    repeat (5) step();
    chk("t3_acc0", acc_i[0], 0);
    chk("t3_acc1", acc_i[1], 2);
    chk("t3_rsp0_idx", rsp_i[0], 0);
    chk("t3_rsp0_prod", rsp_p[0], 6);
    chk("t3_rsp1_idx", rsp_i[1], 2);
    chk("t3_rsp1_prod", rsp_p[1], 35);
    chk("t3_rsp_total", rsp_i.size(), 2);
    chk("t3_onehot", bad, 0);

    // Fairness with all four held continuously
    do_reset();
    auto_drop = 1'b0;
    for (int i = 0; i < NR; i++) set_req(i, fe_t'(i + 1), 3);
    run_until_acc(8, 200);
    req_valid = '0;
    auto_drop = 1'b1;
    for (int k = 0; k < 8; k++) chk($sformatf("t4_order%0d", k), acc_i[k], k % NR);
    for (int k = 1; k < 8; k++) chk($sformatf("t4_gap%0d", k), acc_c[k] - acc_c[k-1], LAT + 4);

    // Reset in the middle of WAIT
    do_reset();
    set_req(1, 4, 4);
    run_until_rsp(1, 40);
    clear_logs();
    set_req(2, 6, 6);
    for (int k = 0; k < 20 && en_c.size() < 1; k++) step();
    chk("t5_launched", en_c.size(), 1);
    repeat (3) step();
    chk("t5_busy_pre", busy, 1);
    rst = 1'b1;
    #1;
    chk("t5_busy", busy, 0);
    chk("t5_mul_en", mul_en, 0);
    chk("t5_rsp_valid", rsp_valid, 0);
    chk("t5_rsp_prod", rsp_prod, 0);
    chk("t5_mul_x", mul_x, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (10) step();
    chk("t5_no_rsp", rsp_i.size(), 0);
    clear_logs();
    for (int i = 0; i < NR; i++) set_req(i, 1, 1);
    run_until_acc(1, 10);
    chk("t5_next_grant", acc_i[0], 0);

    // Watchdog: multiplier never signals done
    do_reset();
    set_req(0, 3, 3);
    run_until_rsp(1, 40);
    chk("t6_pre_prod", rsp_p[0], 9);
    clear_logs();
    stub_hang = 1'b1;
    set_req(3, 7, 7);
`ifdef MULP_ARB_TIMEOUT_EN
    run_until_rsp(1, 60);
    chk("t6_rsp_idx", rsp_i[0], 3);
    chk("t6_err", rsp_e[0], 1);
    chk("t6_prod", rsp_p[0], 0);
    chk("t6_timing", rsp_c[0] - (en_c[0] + 1), TO);
`else
    repeat (100) step();
    chk("t6_busy", busy, 1);
    chk("t6_no_rsp", rsp_i.size(), 0);
    chk("t6_err", rsp_err, 0);
`endif
    stub_hang = 1'b0;
    do_reset();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
